// File: rtl/mux16_rr_sched_pkg.sv
// Shared types and sizing for the 16-lane round-robin mux scheduler.
package mux16_rr_sched_pkg;

    localparam int LANES  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/MUX16to1.sv
// Existing 16:1 single-bit mux; lane i's data bit is w[i], w[0] being the MSB.
module MUX16to1 (
    input  logic [0:15] w,
    input  logic [3:0]  s,
    output logic        f
);

    assign f = w[s];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one MUX16to1 among 16 requesters, with
// completion/withdrawal/timeout release and a mandatory idle gap between grants.
module mux16_rr_sched
    import mux16_rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  req,
    input  logic              done,
    input  logic [0:LANES-1]  w,
    output logic [SEL_W-1:0]  s,
    output logic [LANES-1:0]  gnt,
    output logic              valid,
    output logic              f,
    output logic              timeout
);

    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t              state_reg, state_next;
    logic [SEL_W-1:0]    last_reg, last_next;
    logic [SEL_W-1:0]    s_reg, s_next;
    logic [LANES-1:0]    gnt_reg, gnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                timeout_reg, timeout_next;

    // Request vector rotated so entry 0 is the lane just after the last grant.
    logic [SEL_W-1:0]    cand_idx [LANES];
    logic [LANES-1:0]    rot_req;
    logic [SEL_W-1:0]    winner;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rot
            assign cand_idx[gi] = last_reg + SEL_W'(gi + 1);
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = last_reg;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                winner = cand_idx[i];
            end
        end
    end

    logic withdraw;
    logic hold_hit;

    assign withdraw = ~req[s_reg];
    assign hold_hit = HOLD_EN && (hold_cnt_reg == HOLD_LAST);

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        s_next        = s_reg;
        gnt_next      = gnt_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next    = ST_GRANT;
                    s_next        = winner;
                    gnt_next      = LANES'(1) << winner;
                    last_next     = winner;
                    hold_cnt_next = '0;
                end
            end
            ST_GRANT: begin
                hold_cnt_next = (&hold_cnt_reg) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
                if (done || withdraw || hold_hit) begin
                    state_next   = ST_IDLE;
                    gnt_next     = '0;
                    // Timeout is reported only when it is the sole reason to release.
                    timeout_next = hold_hit && !done && !withdraw;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            last_reg     <= SEL_W'(LANES - 1);
            s_reg        <= '0;
            gnt_reg      <= '0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            s_reg        <= s_next;
            gnt_reg      <= gnt_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    logic mux_f;

    MUX16to1 u_mux (
        .w (w),
        .s (s_reg),
        .f (mux_f)
    );

    assign s       = s_reg;
    assign gnt     = gnt_reg;
    assign valid   = (state_reg == ST_GRANT);
    assign f       = mux_f & valid;
    assign timeout = timeout_reg;

endmodule
